// File: rtl/fir_mc_folded.sv
// Folded multi-channel FIR: one multiplier and one accumulator shared across taps and channels.
// Define FIR_MC_SAT_EN to clamp results to the DATA_WIDTH signed range instead of wrapping.
module fir_mc_folded #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  parameter int FRAC_BITS  = 15,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         sample_in,
  output logic [CW-1:0]                sample_ch,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_din,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]                dout_ch,
  output logic                         sample_out
);
  localparam int PW   = DATA_WIDTH + COEF_WIDTH;
  localparam int ACCW = PW + AW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] MAC    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]                   state;
  logic [CW-1:0]                ch;
  logic [AW-1:0]                k;
  logic signed [ACCW-1:0]       acc;
  logic signed [DATA_WIDTH-1:0] hist [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] coef [TAPS];
  logic signed [PW-1:0]         prod;
  logic signed [ACCW-1:0]       res;
  logic signed [DATA_WIDTH-1:0] res_q;

  assign busy      = (state != IDLE);
  assign sample_in = (state == ACCEPT);
  assign sample_ch = ch;

  // Operands are sign-extended to the full product width before multiplying.
  assign prod = PW'(hist[ch][k]) * PW'(coef[k]);
  assign res  = acc >>> FRAC_BITS;

`ifdef FIR_MC_SAT_EN
  localparam logic signed [ACCW-1:0] RMAX = {{(ACCW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] RMIN = ~RMAX;

  always_comb begin
    res_q = res[DATA_WIDTH-1:0];
    if (res > RMAX)      res_q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (res < RMIN) res_q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  logic unused_res;
  assign res_q      = res[DATA_WIDTH-1:0];
  assign unused_res = ^res[ACCW-1:DATA_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      k          <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      sample_out <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      for (int t = 0; t < TAPS; t++) coef[t] <= '0;
    end else begin
      sample_out <= 1'b0;
      case (state)
        IDLE: begin
          // Coefficients are only writable while the datapath is quiet.
          if (coef_we && (32'(coef_addr) < TAPS)) coef[coef_addr] <= coef_din;
          if (en) state <= ACCEPT;
        end
        ACCEPT: begin
          hist[ch][0] <= din;
          for (int t = 1; t < TAPS; t++) hist[ch][t] <= hist[ch][t-1];
          acc   <= '0;
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          if (k == AW'(TAPS-1)) state <= DONE;
          else                  k     <= k + AW'(1);
        end
        DONE: begin
          dout       <= res_q;
          dout_ch    <= ch;
          sample_out <= 1'b1;
          ch         <= (ch == CW'(CHANNELS-1)) ? '0 : ch + CW'(1);
          state      <= en ? ACCEPT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mc_folded.sv
// Randomized self-checking bench for fir_mc_folded against a sum-of-products reference model.
module tb_fir_mc_folded;
  localparam int TAPS = 4;
  localparam int CH   = 2;
  localparam int FRAC = 0;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, coef_we = 1'b0;
  logic signed [15:0] din = '0, coef_din = '0, dout;
  logic [1:0] coef_addr = '0;
  logic sample_in, sample_out, busy, sample_ch, dout_ch;

  int passed = 0, total = 0;
  bit watch_busy = 1'b0;
  int busy_low_cnt = 0;

  longint m_hist [CH][TAPS];
  longint m_h [TAPS];
  int     m_ch;

  fir_mc_folded #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .CHANNELS(CH), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sample_in(sample_in), .sample_ch(sample_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din), .busy(busy),
    .dout(dout), .dout_ch(dout_ch), .sample_out(sample_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_busy && !busy) busy_low_cnt++;

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < TAPS; t++) m_hist[c][t] = 0;
    for (int t = 0; t < TAPS; t++) m_h[t] = 0;
    m_ch = 0;
  endtask

  // Convolution of the channel's newest TAPS samples with h, then shift and wrap/clamp.
  task automatic model_push(input longint d, output logic signed [15:0] e, output int c);
    longint s = 0;
    c = m_ch;
    for (int t = TAPS-1; t > 0; t--) m_hist[c][t] = m_hist[c][t-1];
    m_hist[c][0] = d;
    for (int t = 0; t < TAPS; t++) s += m_hist[c][t] * m_h[t];
    s = s >>> FRAC;
`ifdef FIR_MC_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    e = s[15:0];
    m_ch = (m_ch + 1) % CH;
  endtask

  task automatic load_coefs(input logic signed [15:0] c [TAPS]);
    en = 1'b0;
    for (int t = 0; t < TAPS; t++) begin
      coef_we = 1'b1; coef_addr = t[1:0]; coef_din = c[t]; m_h[t] = c[t];
      @(negedge clk);
    end
    coef_we = 1'b0;
  endtask

  // Runs one slot from the sampling side: feeds din in the ACCEPT cycle and waits for sample_out.
  task automatic do_slot(input logic signed [15:0] d, input bit last, input bit poke,
                         output logic signed [15:0] q, output logic qch, output logic sch,
                         output int wn, output int lat, output bit ok);
    ok = 1'b0; q = '0; qch = 1'b0; sch = 1'b0; wn = 0; lat = 0;
    en = 1'b1;
    while (!sample_in && wn < 20) begin @(negedge clk); wn++; end
    if (!sample_in) begin en = 1'b0; return; end
    din = d; sch = sample_ch;
    if (last) en = 1'b0;
    @(negedge clk); lat = 1;
    if (poke) begin coef_we = 1'b1; coef_addr = 2'd0; coef_din = 16'sd9; end
    while (!sample_out && lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 3) coef_we = 1'b0;
    end
    coef_we = 1'b0;
    if (!sample_out) begin en = 1'b0; return; end
    q = dout; qch = dout_ch; ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (busy === 1'b0) passed++; else $display("FAIL reset_busy got %b want 0", busy);
    total++; if (sample_in === 1'b0) passed++; else $display("FAIL reset_sample_in got %b want 0", sample_in);
    total++; if (sample_out === 1'b0) passed++; else $display("FAIL reset_sample_out got %b want 0", sample_out);
    total++; if (dout === 16'sd0) passed++; else $display("FAIL reset_dout got %0d want 0", dout);
    total++; if (dout_ch === 1'b0) passed++; else $display("FAIL reset_dout_ch got %b want 0", dout_ch);
    total++; if (sample_ch === 1'b0) passed++; else $display("FAIL reset_sample_ch got %b want 0", sample_ch);
    repeat (3) @(negedge clk);
    total++; if (busy === 1'b0) passed++; else $display("FAIL idle_hold_busy got %b want 0", busy);
  endtask

  task automatic test_impulse(input string name);
    logic signed [15:0] c [TAPS] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    logic signed [15:0] ch0_exp [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0};
    logic signed [15:0] q, e, want;
    logic qch, sch;
    int wn, lat, mc;
    bit ok;
    load_coefs(c);
    for (int i = 0; i < 10; i++) begin
      do_slot((i == 0) ? 16'sd1 : 16'sd0, i == 9, 1'b0, q, qch, sch, wn, lat, ok);
      model_push((i == 0) ? 1 : 0, e, mc);
      want = (i % 2 == 0) ? ch0_exp[i/2] : 16'sd0;
      total++; if (ok) passed++; else $display("FAIL %s_timeout slot %0d", name, i);
      total++; if (q === want) passed++; else $display("FAIL %s_dout slot %0d got %0d want %0d", name, i, q, want);
      total++; if (qch === i[0]) passed++; else $display("FAIL %s_dout_ch slot %0d got %b want %b", name, i, qch, i[0]);
    end
  endtask

  task automatic test_isolation();
    logic signed [15:0] c [TAPS] = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    logic signed [15:0] q, e, d;
    logic qch, sch;
    int wn, lat, mc;
    bit ok;
    load_coefs(c);
    for (int i = 0; i < 16; i++) begin
      d = (i % 2 == 0) ? 16'sd10 : -16'sd5;
      do_slot(d, i == 15, 1'b0, q, qch, sch, wn, lat, ok);
      model_push(d, e, mc);
      total++; if (ok && q === e) passed++; else $display("FAIL isolation_dout slot %0d got %0d want %0d", i, q, e);
      total++; if (sch === mc[0] && qch === mc[0]) passed++;
      else $display("FAIL isolation_ch slot %0d got %b/%b want %0d", i, sch, qch, mc);
      if (i >= 6) begin
        total++;
        if (q === ((i % 2 == 0) ? 16'sd40 : -16'sd20)) passed++;
        else $display("FAIL isolation_steady slot %0d got %0d want %0d", i, q, (i % 2 == 0) ? 40 : -20);
      end
    end
  endtask

  task automatic test_timing();
    logic signed [15:0] q, e, d;
    logic qch, sch;
    int wn, lat, mc, base;
    bit ok;
    base = busy_low_cnt;
    for (int i = 0; i < 9; i++) begin
      d = 16'($urandom);
      do_slot(d, i == 8, 1'b0, q, qch, sch, wn, lat, ok);
      model_push(d, e, mc);
      if (i == 0) watch_busy = 1'b1;
      if (i == 7) watch_busy = 1'b0;
      total++; if (ok && lat == 6) passed++; else $display("FAIL timing_latency slot %0d got %0d want 6", i, lat);
      if (i > 0) begin
        total++; if (wn == 0) passed++; else $display("FAIL timing_period slot %0d extra wait %0d want 0", i, wn);
      end
      total++; if (q === e) passed++; else $display("FAIL timing_dout slot %0d got %0d want %0d", i, q, e);
    end
    total++; if (busy_low_cnt == base) passed++;
    else $display("FAIL timing_busy_drop got %0d low cycles want 0", busy_low_cnt - base);
    total++; if (busy === 1'b0) passed++; else $display("FAIL en_drop_idle busy got %b want 0", busy);
  endtask

  task automatic test_overflow();
    logic signed [15:0] c [TAPS] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
    logic signed [15:0] q, e, want;
    logic qch, sch;
    int wn, lat, mc;
    bit ok;
`ifdef FIR_MC_SAT_EN
    want = 16'sh7FFF;
`else
    want = 16'sh0004;
`endif
    load_coefs(c);
    for (int i = 0; i < 8; i++) begin
      do_slot(16'sh7FFF, i == 7, 1'b0, q, qch, sch, wn, lat, ok);
      model_push(32767, e, mc);
      total++; if (ok && q === e) passed++; else $display("FAIL overflow_model slot %0d got %0d want %0d", i, q, e);
      if (i >= 6) begin
        total++; if (q === want) passed++; else $display("FAIL overflow_value slot %0d got %h want %h", i, q, want);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] c [TAPS];
    logic signed [15:0] q, e, d;
    logic qch, sch;
    int wn, lat, mc;
    bit ok;
    for (int t = 0; t < TAPS; t++) c[t] = 16'($urandom);
    load_coefs(c);
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      do_slot(d, i == 11, 1'b0, q, qch, sch, wn, lat, ok);
      model_push(d, e, mc);
      total++; if (ok && q === e) passed++; else $display("FAIL random_dout slot %0d got %0d want %0d", i, q, e);
      total++; if (qch === mc[0]) passed++; else $display("FAIL random_dout_ch slot %0d got %b want %0d", i, qch, mc);
    end
  endtask

  task automatic test_reset_mid_mac();
    int n = 0, pulses = 0;
    en = 1'b1;
    while (!sample_in && n < 20) begin @(negedge clk); n++; end
    total++; if (sample_in) passed++; else $display("FAIL midrst_start got sample_in %b want 1", sample_in);
    din = 16'sd123;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (dout === 16'sd0 && dout_ch === 1'b0) passed++;
    else $display("FAIL midrst_dout got %0d/%b want 0/0", dout, dout_ch);
    total++; if (!busy && !sample_in && !sample_out && !sample_ch) passed++;
    else $display("FAIL midrst_flags got busy=%b in=%b out=%b ch=%b want 0", busy, sample_in, sample_out, sample_ch);
    repeat (10) begin if (sample_out) pulses++; @(negedge clk); end
    total++; if (pulses == 0) passed++; else $display("FAIL midrst_no_pulse got %0d pulses want 0", pulses);
    test_impulse("midrst_impulse");
  endtask

  task automatic test_busy_coef_write();
    logic signed [15:0] q, e;
    logic qch, sch;
    int wn, lat, mc;
    bit ok;
    do_slot(16'sd5, 1'b1, 1'b1, q, qch, sch, wn, lat, ok);
    model_push(5, e, mc);
    total++; if (ok && lat == 6) passed++; else $display("FAIL busywr_latency got %0d want 6", lat);
    total++; if (q === 16'sd5 && q === e) passed++; else $display("FAIL busywr_ignored got %0d want 5", q);
    coef_we = 1'b1; coef_addr = 2'd0; coef_din = 16'sd9; m_h[0] = 9;
    @(negedge clk);
    coef_we = 1'b0;
    do_slot(16'sd7, 1'b1, 1'b0, q, qch, sch, wn, lat, ok);
    model_push(7, e, mc);
    total++; if (ok && q === 16'sd63 && q === e) passed++; else $display("FAIL idlewr_ch1 got %0d want 63", q);
    do_slot(16'sd1, 1'b1, 1'b0, q, qch, sch, wn, lat, ok);
    model_push(1, e, mc);
    total++; if (ok && q === 16'sd19 && q === e) passed++; else $display("FAIL idlewr_ch0 got %0d want 19", q);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_impulse("impulse");
    test_isolation();
    test_timing();
    test_overflow();
    test_random();
    test_reset_mid_mac();
    test_busy_coef_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
